// File: rtl/seven_segment_scanner.sv
// Multiplexed hex seven-segment driver with a guard blank, 4-bit duty-cycle brightness,
// and frame-synchronous double buffering of the display data.
module seven_segment_scanner #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SUB_DIV        = 1024,
  parameter bit          COMMON_ANODE   = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [3:0]            brightness,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int unsigned PreW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [PreW-1:0] PreLast = PreW'(SUB_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [6:0]        SegOff  = {7{COMMON_ANODE}};
  localparam logic [DIGITS-1:0] SelOff  = {DIGITS{SEL_ACTIVE_LOW}};

  logic [PreW-1:0]     pre_q;
  logic [3:0]          phase_q;
  logic [IdxW-1:0]     idx_q;

  logic [4*DIGITS-1:0] sh_digits_q, act_digits_q;
  logic [DIGITS-1:0]   sh_dp_q, act_dp_q;
  logic [DIGITS-1:0]   sh_en_q, act_en_q;
  logic [3:0]          sh_br_q, act_br_q;

  logic                pre_wrap, phase_wrap, boundary, drive;
  logic [3:0]          nibble;
  logic [6:0]          seg_dec;
  logic [DIGITS-1:0]   sel_hot;

  always_comb begin
    pre_wrap   = (pre_q == PreLast);
    phase_wrap = pre_wrap && (phase_q == 4'hF);
    boundary   = phase_wrap && (idx_q == IdxLast);
    nibble     = act_digits_q[{idx_q, 2'b00} +: 4];
    // Phase 0 is always dark so the previous digit's charge never ghosts onto the next one.
    drive      = act_en_q[idx_q] && (phase_q != 4'h0) && (phase_q <= act_br_q);
    sel_hot    = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end

  always_comb begin
    seg_dec = 7'h00;
    unique case (nibble)
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h6F;
      4'hA: seg_dec = 7'h77;
      4'hB: seg_dec = 7'h7C;
      4'hC: seg_dec = 7'h39;
      4'hD: seg_dec = 7'h5E;
      4'hE: seg_dec = 7'h79;
      4'hF: seg_dec = 7'h71;
      default: seg_dec = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      sh_br_q      <= '0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      act_br_q     <= '0;
      segments     <= SegOff;
      dp           <= COMMON_ANODE;
      digit_sel    <= SelOff;
      frame_start  <= 1'b0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + PreW'(1);
      if (pre_wrap) phase_q <= phase_q + 4'd1;
      if (phase_wrap) idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);

      if (load) begin
        sh_digits_q <= digits_in;
        sh_dp_q     <= dp_in;
        sh_en_q     <= digit_en;
        sh_br_q     <= brightness;
      end
      // A load on the boundary cycle itself is deferred: active copies the pre-load shadow.
      if (boundary) begin
        act_digits_q <= sh_digits_q;
        act_dp_q     <= sh_dp_q;
        act_en_q     <= sh_en_q;
        act_br_q     <= sh_br_q;
      end
      frame_start <= boundary;

      if (drive) begin
        segments  <= seg_dec ^ SegOff;
        dp        <= act_dp_q[idx_q] ^ COMMON_ANODE;
        digit_sel <= sel_hot ^ SelOff;
      end else begin
        segments  <= SegOff;
        dp        <= COMMON_ANODE;
        digit_sel <= SelOff;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: two instances (active-high/SUB_DIV=1 and
// inverted/SUB_DIV=2) checked every cycle against a time-based reference model.
module tb_seven_segment_scanner;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  br;
  } disp_t;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } vec_t;

  localparam logic [6:0] SegTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  brightness = '0;
  logic        load = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fs_a, fs_b;
  logic [3:0]  sel_a, sel_b;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  disp_t sh, act_a, act_b;

  always #5 clk = ~clk;

  seven_segment_scanner #(.DIGITS(4), .SUB_DIV(1), .COMMON_ANODE(1'b0), .SEL_ACTIVE_LOW(1'b0))
  u_dut_a (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .brightness(brightness), .load(load), .segments(seg_a), .dp(dp_a), .digit_sel(sel_a),
    .frame_start(fs_a)
  );

  seven_segment_scanner #(.DIGITS(4), .SUB_DIV(2), .COMMON_ANODE(1'b1), .SEL_ACTIVE_LOW(1'b1))
  u_dut_b (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .brightness(brightness), .load(load), .segments(seg_b), .dp(dp_b), .digit_sel(sel_b),
    .frame_start(fs_b)
  );

  // Outputs expected after the edge that samples time step n (n cycles since reset release).
  function automatic logic [12:0] exp_out(input int sd, input bit ca, input bit sl, input int n,
                                          input disp_t a);
    int pos, idx, ph;
    bit drv;
    logic [6:0] s;
    logic d;
    logic [3:0] sel;
    pos = n % (64 * sd);
    idx = pos / (16 * sd);
    ph  = (pos / sd) % 16;
    drv = a.en[idx] && ph != 0 && ph <= int'(a.br);
    s   = drv ? SegTab[a.d[idx*4 +: 4]] : 7'h00;
    d   = drv ? a.dp[idx] : 1'b0;
    sel = drv ? 4'(1 << idx) : 4'h0;
    if (ca) begin
      s = ~s;
      d = ~d;
    end
    if (sl) sel = ~sel;
    return {s, d, sel, (pos == 64 * sd - 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cnt=%0d: got=%h want=%h", name, cnt, got, want);
    end
  endtask

  task automatic tick();
    logic [12:0] ea, eb;
    ea = exp_out(1, 1'b0, 1'b0, cnt, act_a);
    eb = exp_out(2, 1'b1, 1'b1, cnt, act_b);
    @(posedge clk);
    if (cnt % 64 == 63) act_a = sh;
    if (cnt % 128 == 127) act_b = sh;
    if (load) sh = '{d: digits_in, dp: dp_in, en: digit_en, br: brightness};
    cnt++;
    #1;
    check("model_a", {3'b0, seg_a, dp_a, sel_a, fs_a}, {3'b0, ea});
    check("model_b", {3'b0, seg_b, dp_b, sel_b, fs_b}, {3'b0, eb});
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                         input logic [3:0] b);
    digits_in = d;
    dp_in = p;
    digit_en = e;
    brightness = b;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_mod(input int m, input int r);
    while (cnt % m != r) tick();
  endtask

  initial begin
    vec_t vecs[16];
    int   n_a, n_b, runs_b, last_fs, waited;
    int   per_dig[4];
    logic prev_b;

    vecs = '{'{4'h0, 7'h3F}, '{4'h1, 7'h06}, '{4'h2, 7'h5B}, '{4'h3, 7'h4F},
             '{4'h4, 7'h66}, '{4'h5, 7'h6D}, '{4'h6, 7'h7D}, '{4'h7, 7'h07},
             '{4'h8, 7'h7F}, '{4'h9, 7'h6F}, '{4'hA, 7'h77}, '{4'hB, 7'h7C},
             '{4'hC, 7'h39}, '{4'hD, 7'h5E}, '{4'hE, 7'h79}, '{4'hF, 7'h71}};
    sh = '0;
    act_a = '0;
    act_b = '0;

    #12;
    check("reset_a", {3'b0, seg_a, dp_a, sel_a, fs_a}, 16'h0000);
    check("reset_b", {3'b0, seg_b, dp_b, sel_b, fs_b}, {3'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan with full brightness; frame_start period on A.
    do_load(16'h4321, 4'h0, 4'hF, 4'hF);
    to_mod(128, 0);
    last_fs = -1;
    for (int i = 0; i < 192; i++) begin
      tick();
      if (fs_a) begin
        if (last_fs >= 0) check("fs_period_a", 16'(cnt - last_fs), 16'd64);
        last_fs = cnt;
      end
    end

    // Decode table on A, slot 0, phase 1.
    foreach (vecs[i]) begin
      do_load({4{vecs[i].val}}, 4'h0, 4'h1, 4'hF);
      to_mod(64, 0);
      run(2);
      check("decode_a", {9'b0, seg_a}, {9'b0, vecs[i].seg});
    end

    // Brightness 4: 4 (A) / 8 (B) lit cycles per slot.
    do_load(16'h1234, 4'h0, 4'hF, 4'h4);
    to_mod(128, 0);
    run(128);
    n_a = 0; n_b = 0; runs_b = 0; prev_b = 1'b0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (sel_a != 4'h0) n_a++;
      if (sel_b != 4'hF) n_b++;
      if (sel_b != 4'hF && !prev_b) runs_b++;
      prev_b = (sel_b != 4'hF);
    end
    check("bright4_a", 16'(n_a), 16'd32);
    check("bright4_b", 16'(n_b), 16'd32);
    check("bright4_runs_b", 16'(runs_b), 16'd4);

    // Brightness 0: fully dark.
    do_load(16'h8888, 4'hF, 4'hF, 4'h0);
    to_mod(128, 0);
    run(128);
    n_a = 0; n_b = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (sel_a != 4'h0 || seg_a != 7'h00) n_a++;
      if (sel_b != 4'hF) n_b++;
    end
    check("bright0_a", 16'(n_a), 16'd0);
    check("bright0_b", 16'(n_b), 16'd0);

    // digit_en 0101: slots 1 and 3 blank.
    do_load(16'h4321, 4'h0, 4'b0101, 4'hF);
    to_mod(128, 0);
    run(64);
    per_dig = '{0, 0, 0, 0};
    for (int i = 0; i < 64; i++) begin
      tick();
      for (int k = 0; k < 4; k++) if (sel_a == 4'(1 << k)) per_dig[k]++;
    end
    for (int k = 0; k < 4; k++) check("en_slot_a", 16'(per_dig[k]), (k % 2 == 0) ? 16'd15 : 16'd0);

    // Mid-frame load, then a load on the boundary cycle (deferred one frame).
    do_load(16'h4321, 4'h0, 4'hF, 4'hF);
    to_mod(128, 0);
    to_mod(64, 20);
    do_load(16'hABCD, 4'h0, 4'hF, 4'hF);
    run(150);
    to_mod(64, 63);
    do_load(16'h5678, 4'h0, 4'hF, 4'hF);
    run(2);
    check("boundary_load_deferred_a", {9'b0, seg_a}, {9'b0, 7'h5E});
    run(140);

    // Inverted polarity on B: digit 8 with dp.
    do_load(16'h8888, 4'hF, 4'hF, 4'hF);
    to_mod(128, 0);
    run(1);
    waited = 0;
    while (sel_b == 4'hF && waited < 300) begin
      tick();
      waited++;
    end
    check("ca_drive_b", {3'b0, seg_b, dp_b, 4'h0, 1'b0}, 16'h0000);
    check("ca_sel_b", {12'b0, sel_b}, {12'b0, 4'b1110});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        tick();
    end

    // Reset during slot 2 phase 7 on A.
    do_load(16'h9999, 4'h0, 4'hF, 4'hF);
    to_mod(128, 0);
    run(40);
    check("pre_reset_driving_a", {12'b0, sel_a}, 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", {3'b0, seg_a, dp_a, sel_a, fs_a}, 16'h0000);
    check("async_reset_b", {3'b0, seg_b, dp_b, sel_b, fs_b}, {3'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
    sh = '0;
    act_a = '0;
    act_b = '0;
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h0000, 4'h0, 4'hF, 4'hF);
    waited = 0;
    while (sel_a == 4'h0 && waited < 300) begin
      tick();
      waited++;
    end
    check("post_reset_first_cnt", 16'(cnt), 16'd66);
    check("post_reset_first_a", {5'b0, seg_a, sel_a}, {5'b0, 7'h3F, 4'h1});
    run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Time-multiplexes one shared hex-to-seven-segment decode across DIGITS common-segment digits.
- Sequences the digit strobes with a guard blank before each digit and applies 4-bit brightness via duty cycle.
- Double-buffers display data so a frame never mixes old and new values.
- Sits between counter/timer logic (digit values) and the board's segment/digit pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SUB_DIV, 1024, clk cycles per sub-phase (>=1); one digit slot = 16*SUB_DIV cycles.
- COMMON_ANODE, 1, 1 = segments and dp driven active-low; 0 = active-high.
- SEL_ACTIVE_LOW, 0, 1 = digit_sel active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  4*DIGITS  hex values; digit k = digits_in[4k+3:4k].
- dp_in  in  DIGITS  decimal point per digit.
- digit_en  in  DIGITS  1 = digit displayed, 0 = digit blanked (slot time still consumed).
- brightness  in  4  duty level 0..15.
- load  in  1  single-cycle strobe; captures digits_in/dp_in/digit_en/brightness into the shadow buffer.
- segments  out  7  {g,f,e,d,c,b,a}; bit0 = a.
- dp  out  1  decimal point.
- digit_sel  out  DIGITS  one-hot digit strobe.
- frame_start  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async assert, sync release):
  - pre, phase, idx, shadow, active and pending all 0.
  - Outputs inactive: segments at off level (7'h00 if COMMON_ANODE=0, 7'h7F if 1); dp off; digit_sel all inactive; frame_start 0.
- Counters:
  - pre counts 0..SUB_DIV-1. At wrap, phase increments 0..15.
  - At phase wrap 15->0, idx increments 0..DIGITS-1, then wraps to 0.
- Frame boundary: the cycle in which idx wraps DIGITS-1 -> 0.
  - active <= shadow.
  - frame_start registered high for exactly one cycle.
- load:
  - Sets shadow on the load cycle. New values take effect only at the next frame boundary.
  - load on the boundary cycle itself: active takes the pre-load shadow, and the new data applies one frame later.
  - Multiple loads within a frame: the last one wins.
- Drive condition for slot idx: active.digit_en[idx] && phase != 0 && phase <= active.brightness.
  - Phase 0 is always blank (ghost guard).
  - brightness 0 = fully dark; 15 = 15/16 duty.
- While driving:
  - digit_sel = one-hot bit idx.
  - segments = decode(active nibble idx); dp = active.dp[idx].
  - All three polarity-adjusted.
- While not driving: segments, dp and digit_sel all at inactive level.
- Decode (active-high form): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - COMMON_ANODE=1 inverts segments and dp.
  - SEL_ACTIVE_LOW=1 inverts digit_sel.
- Latency: all outputs registered; outputs at cycle t+1 reflect counter/active state at cycle t.
- Invariants:
  - At most one digit_sel bit active at any time.
  - digit_sel never changes to a different digit without at least SUB_DIV inactive cycles in between.
- Timing: frame period = DIGITS*16*SUB_DIV cycles, exact and free-running; not affected by load.
- Reset mid-frame: outputs go inactive immediately (async); scan restarts at idx 0, phase 0 after release.

Test Plan:
1. Default params except SUB_DIV=1, COMMON_ANODE=0; load digits_in=16'h4321, digit_en=4'hF, brightness=15.
   - After first boundary, slot idx k drives digit_sel=1<<k for phases 1..15, i.e. 15 of every 16 cycles.
   - Segments per slot: 06, 5B, 4F, 66.
   - frame_start pulses every 64 cycles.
2. brightness=4, SUB_DIV=2: each slot shows digit_sel active for exactly 8 consecutive cycles, preceded by 2 guard cycles. brightness=0: digit_sel never active; segments stay 7'h00.
3. Load 16'hABCD mid-frame (idx=1):
   - Remaining slots of the current frame still show the old digits.
   - The next frame shows 77, 7C, 39, 5E for digits 3..0.
   - Also check load asserted on the boundary cycle is deferred one frame.
4. digit_en=4'b0101: slots 1 and 3 fully blank (digit_sel inactive all 16 cycles); slots 0 and 2 normal; frame_start period unchanged.
5. COMMON_ANODE=1, SEL_ACTIVE_LOW=1, value 8 with dp_in set:
   - While driving: segments=7'h00, dp=0, digit_sel low on the active bit only.
   - While idle: segments=7'h7F, dp=1, digit_sel all 1s.
6. Assert rst_n low during slot 2 phase 7: outputs go inactive in the same cycle without waiting for clk. After release, the first digit_sel activation is digit 0 at phase 1, with shadow/active cleared (displays 0s, segments 3F).
